// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue/collect sequencer.
// ALU control codes, ALUOp encodings, R-type funct values, FSM states.
package alu_issue_pkg;

    localparam logic [3:0] CTR_AND = 4'b0000;
    localparam logic [3:0] CTR_OR  = 4'b0001;
    localparam logic [3:0] CTR_ADD = 4'b0010;
    localparam logic [3:0] CTR_SUB = 4'b0110;
    localparam logic [3:0] CTR_SLT = 4'b0111;
    localparam logic [3:0] CTR_NOR = 4'b1100;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Request and response valid/ready bundle for alu_issue.
// master = requester/consumer side, slave = alu_issue.
interface alu_issue_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_alu_op;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_illegal;

    modport master (
        output req_valid, req_alu_op, req_funct, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_illegal
    );

    modport slave (
        input  req_valid, req_alu_op, req_funct, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational {ALUOp, funct} to ALU control decode.
// Unknown R-type funct decodes to add and raises illegal.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic       illegal
);

    always_comb begin
        alu_ctr = CTR_ADD;
        illegal = 1'b0;
        unique case (alu_op)
            OP_ADD: alu_ctr = CTR_ADD;
            OP_SUB: alu_ctr = CTR_SUB;
            OP_OR:  alu_ctr = CTR_OR;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctr = CTR_ADD;
                    FN_SUB:  alu_ctr = CTR_SUB;
                    FN_AND:  alu_ctr = CTR_AND;
                    FN_OR:   alu_ctr = CTR_OR;
                    FN_SLT:  alu_ctr = CTR_SLT;
                    FN_NOR:  alu_ctr = CTR_NOR;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue/collect sequencer in front of the 32-bit MIPS ALU.
// Define ALU_ISSUE_ILLEGAL_EN to flag illegal funct with a zeroed response.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  io,
    output logic [31:0] alu_input1,
    output logic [31:0] alu_input2,
    output logic [3:0]  alu_ctr,
    input  logic [31:0] alu_res
);

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    state_t      state, state_n;
    logic [3:0]  dec_ctr;
    logic        dec_ill;
    logic        ill_q;
    logic        accept;
    logic        drop;
    logic        vld_q;
    logic [31:0] res_q;
    logic        zero_q;
    logic        ill_rsp_q;

    alu_issue_decode u_dec (
        .alu_op  (io.req_alu_op),
        .funct   (io.req_funct),
        .alu_ctr (dec_ctr),
        .illegal (dec_ill)
    );

    // rsp_ready feeds req_ready so a drained response can overlap the next accept
    assign io.req_ready = rst_n &&
        (state == IDLE || (state == RESP && io.rsp_ready));
    assign accept = io.req_valid && io.req_ready;
    assign drop   = ill_q & ILL_EN;

    assign io.rsp_valid   = vld_q;
    assign io.rsp_res     = res_q;
    assign io.rsp_zero    = zero_q;
    assign io.rsp_illegal = ill_rsp_q;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (io.req_valid) state_n = EXEC;
            EXEC: state_n = RESP;
            RESP: begin
                if (io.rsp_ready)
                    state_n = io.req_valid ? EXEC : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_ctr    <= CTR_ADD;
            ill_q      <= 1'b0;
            vld_q      <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            ill_rsp_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_input1 <= io.req_a;
                alu_input2 <= io.req_b;
                alu_ctr    <= dec_ctr;
                ill_q      <= dec_ill;
            end
            if (state == EXEC) begin
                res_q     <= drop ? '0 : alu_res;
                zero_q    <= drop | (alu_res == '0);
                ill_rsp_q <= drop;
            end
            vld_q <= (state_n == RESP);
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard testbench for alu_issue with an attached behavioural ALU.
// Works with or without ALU_ISSUE_ILLEGAL_EN defined.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_input1, alu_input2, alu_res;
    logic [3:0]  alu_ctr;
    int          cyc;
    int          acc_cyc;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    alu_issue_if bus();

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (bus),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_ctr    (alu_ctr),
        .alu_res    (alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_res = 32'h0;
        case (alu_ctr)
            4'b0000: alu_res = alu_input1 & alu_input2;
            4'b0001: alu_res = alu_input1 | alu_input2;
            4'b0010: alu_res = alu_input1 + alu_input2;
            4'b0110: alu_res = alu_input1 - alu_input2;
            4'b0111: alu_res = {31'd0,
                        $signed(alu_input1) < $signed(alu_input2)};
            4'b1100: alu_res = ~(alu_input1 | alu_input2);
            default: alu_res = 32'h0;
        endcase
    end

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every completed response handshake is checked against the queue
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_res", bus.rsp_res, e.res);
                chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
                chk("rsp_illegal", {31'd0, bus.rsp_illegal},
                    {31'd0, e.ill});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei);
        logic got;
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_alu_op = op;
        bus.req_funct  = fn;
        bus.req_a      = a;
        bus.req_b      = b;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            acc_cyc = cyc;
            e.res  = er;
            e.zero = (er == 32'h0);
            e.ill  = ei;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", sb.size(), 32'd0);
    endtask

    logic [31:0] ill_res;
    logic        ill_flag;
    int          a1;

    initial begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        ill_res  = 32'h0;
        ill_flag = 1'b1;
`else
        ill_res  = 32'd11;
        ill_flag = 1'b0;
`endif
        cyc = 0;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_alu_op = 2'b00;
        bus.req_funct  = 6'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.rsp_ready  = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_res", bus.rsp_res, 32'd0);
        chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
        chk("rst_alu_ctr", {28'd0, alu_ctr}, 32'd2);
        chk("rst_alu_input1", alu_input1, 32'd0);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;

        // add 5+7 with latency: EXEC cycle, then response visible
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge clk);
        chk("lat_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("lat_exec_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("lat_resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        drain();

        issue(2'b01, 6'b000000, 32'h1234, 32'h1234, 32'd0, 1'b0);
        @(negedge clk);
        chk("sub_alu_ctr", {28'd0, alu_ctr}, 32'd6);
        drain();
        issue(2'b10, 6'b101010, 32'd3, 32'd9, 32'd1, 1'b0);
        drain();
        issue(2'b10, 6'b100010, 32'd3, 32'd9, 32'hFFFFFFFA, 1'b0);
        issue(2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0,
              32'h0F000F00, 1'b0);
        drain();

        // stall: response held, next request waits, then same-edge accept
        bus.rsp_ready = 1'b0;
        issue(2'b00, 6'b000000, 32'd100, 32'd4, 32'd104, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_alu_op = 2'b11;
        bus.req_funct  = 6'b000000;
        bus.req_a      = 32'h0F00;
        bus.req_b      = 32'h00F0;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_res", bus.rsp_res, 32'd104);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        begin
            exp_t e;
            e.res = 32'h0FF0; e.zero = 1'b0; e.ill = 1'b0;
            sb.push_back(e);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("overlap_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("overlap_alu_ctr", {28'd0, alu_ctr}, 32'd1);
        chk("overlap_alu_input1", alu_input1, 32'h0F00);
        drain();

        // back-to-back nor then or
        issue(2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);
        a1 = acc_cyc;
        issue(2'b10, 6'b100101, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        chk("b2b_spacing", acc_cyc - a1, 32'd2);
        drain();

        issue(2'b10, 6'b000000, 32'd5, 32'd6, ill_res, ill_flag);
        @(negedge clk);
        chk("illegal_alu_ctr", {28'd0, alu_ctr}, 32'd2);
        drain();

        // reset in EXEC drops the transaction
        issue(2'b10, 6'b100000, 32'd1, 32'd2, 32'd3, 1'b0);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("exec_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("exec_rst_input1", alu_input1, 32'd0);
        chk("exec_rst_input2", alu_input2, 32'd0);
        chk("exec_rst_ctr", {28'd0, alu_ctr}, 32'd2);
        chk("exec_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("exec_rst_hold_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_rst_res", bus.rsp_res, 32'd0);
        @(posedge clk); #1;
        issue(2'b10, 6'b100000, 32'd10, 32'd20, 32'd30, 1'b0);
        drain();
        issue(2'b11, 6'b000000, 32'h0, 32'h0, 32'h0, 1'b0);
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
